// File: rtl/iob_ram_2p.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
// Read data appears the cycle after r_en and holds while r_en is low.
module iob_ram_2p #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage and output register are intentionally unreset.
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
    if (r_en) r_data <= mem[r_addr];
  end

endmodule

// File: rtl/iob_fifo_sync.sv
// Single-clock FIFO around iob_ram_2p: pointers, word counter and flag decode.
// Flags derive only from the level register, so no request-to-flag path exists.
module iob_fifo_sync #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_empty,
  output logic [ADDR_W:0]   level
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic              push;
  logic              pop;

  assign w_full  = (level == LVL_W'(DEPTH));
  assign r_empty = (level == '0);
  assign push    = w_en && !w_full;
  assign pop     = r_en && !r_empty;

  // Pointers wrap naturally at ADDR_W bits; level tracks occupancy.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
    end else begin
      if (push) w_ptr <= w_ptr + ADDR_W'(1);
      if (pop)  r_ptr <= r_ptr + ADDR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  iob_ram_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .w_en   (push),
    .w_addr (w_ptr),
    .w_data (w_data),
    .r_en   (pop),
    .r_addr (r_ptr),
    .r_data (r_data)
  );

endmodule

// File: doc/iob_fifo_sync.md
# iob_fifo_sync

Synchronous single-clock FIFO that owns both ends of an `iob_ram_2p` instance: it generates write and read addresses, enables and flow control. Producers push through the write port, consumers pop through the read port. Read data arrives one cycle after an accepted pop, matching the registered read port of `iob_ram_2p`. It is the standard buffer between stream blocks in the memory subsystem.

## Interface
- `DATA_W`, 8, data word width in bits
- `ADDR_W`, 4, address width; depth = 2**`ADDR_W` words

- `clk`  input  1  system clock, rising edge
- `arst_n`  input  1  reset, asynchronous, active-low
- `w_en`  input  1  push request
- `w_data`  input  `DATA_W`  push data
- `w_full`  output  1  FIFO holds 2**`ADDR_W` words; push is ignored
- `r_en`  input  1  pop request
- `r_data`  output  `DATA_W`  popped word, valid the cycle after an accepted pop
- `r_empty`  output  1  FIFO holds 0 words; pop is ignored
- `level`  output  `ADDR_W`+1  current word count, 0..2**`ADDR_W`

## Operation
- One clock; reset is asynchronous and active-low.
- Push accepted iff `w_en && !w_full`. The word is written to RAM at `w_ptr`, and `w_ptr` increments.
- Pop accepted iff `r_en && !r_empty`. RAM reads `r_ptr`, and `r_ptr` increments.
- `w_ptr` and `r_ptr` are `ADDR_W` bits wide and wrap from 2**`ADDR_W`-1 to 0 with no extra logic.
- `level` changes as follows: +1 on push only, -1 on pop only, unchanged on both or neither.
- `w_full` = (`level` == 2**`ADDR_W`). `r_empty` = (`level` == 0). Both are decoded from the `level` register, so they have no combinational path from `w_en` or `r_en`.
- Simultaneous push+pop when full: pop accepted, push rejected, `level` ends at 2**`ADDR_W`-1.
- Simultaneous push+pop when empty: push accepted, pop rejected, `level` ends at 1. There is no fall-through.
- Simultaneous push+pop otherwise: both accepted, `level` unchanged.
- Rejected requests (overflow or underflow) change no state, and no error is flagged.
- RAM enables are gated: RAM `w_en` = accepted push, RAM `r_en` = accepted pop. `r_data` therefore holds its last value when no pop is accepted.
- Reset values: `w_ptr`=0, `r_ptr`=0, `level`=0, `r_empty`=1, `w_full`=0.
- `r_data` is the RAM output register and is not reset. It is meaningless until the first accepted pop.
- Reset mid-operation flushes the FIFO immediately, regardless of clock. RAM contents are retained but unreachable.

## Timing
- Push at edge N: `level` and `r_empty` update after edge N. The word can be popped at edge N+1.
- Pop at edge N: `r_data` is valid after edge N and holds until the next accepted pop. `level` and `w_full` update after edge N.
- Back-to-back pushes or pops are sustained at one per cycle.
- Pop-to-data latency is 1 cycle, fixed.

## Structure
- No shared package. `localparam DEPTH = 2**ADDR_W` is local to the module.
- One sub-module: `iob_ram_2p`, instantiated unchanged with `DATA_W` and `ADDR_W` passed through.
- The FIFO contains only the pointers, the `level` counter and the flag decode.

## Test plan
All cases use `DATA_W`=8, `ADDR_W`=4.
- Reset, no traffic: `r_empty`=1, `w_full`=0, `level`=0. A pop request leaves `level`=0.
- Push 16 words 32..47 back-to-back: `level` reaches 16 and `w_full`=1 after the 16th edge. A 17th push with value 99 is ignored and `level` stays 16.
- Pop 16 words back-to-back: `r_data` = 32..47 in order, each valid one cycle after its pop. `r_empty`=1 after the last pop. A further pop leaves `r_data`=47.
- Wrap-around: push 10, pop 10, then push 12 words 100..111 and pop 12. Data is 100..111 in order across the pointer wrap.
- Simultaneous push+pop: at `level`=16, only the pop is accepted and `level`=15. At `level`=0, only the push is accepted and `level`=1. At `level`=5, both are accepted and `level` stays 5 with data order preserved.
- Assert `arst_n`=0 mid-stream at `level`=7, off a clock edge: `level`=0, `r_empty`=1 and `w_full`=0 immediately. After release, a push of 55 then a pop returns 55.
